// File: rtl/group0_mul_arbiter.sv
// group0_mul_arbiter
// Round-robin arbiter that shares one external pipelined signed multiplier
// among NUM_REQ requesters. A {valid, id} tag pipe runs alongside the
// multiplier's registers so each product leaves with its owner's index.
// Response backpressure freezes the tag pipe and the multiplier together
// through mul_ce, so a result is never dropped or duplicated.
module group0_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 64,
    parameter int MUL_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [DATA_W-1:0]         mul_dout,
    output logic                      busy
);

    // Index of the most recently granted requester; the scan starts just after it.
    logic [ID_W-1:0]    ptr;

    // Tag pipe: stage MUL_LAT-1 lines up with mul_dout.
    logic [MUL_LAT-1:0] tag_vld;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    logic               stall;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic               grant;

    assign rsp_valid = tag_vld[MUL_LAT-1];
    assign rsp_id    = tag_id[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |tag_vld;

    // A result waiting on the consumer freezes the multiplier and the tag pipe.
    assign stall     = rsp_valid & ~rsp_ready;
    assign mul_ce    = ~stall;

    // No grant while stalled or while reset is held, so nothing is accepted that
    // the pipe cannot record.
    assign grant     = gnt_any & ~stall & reset;

    // Round-robin pick: lowest valid index above ptr, else lowest valid index at or below ptr.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_any = 1'b0;
        gnt_id  = '0;
        // Wrap-around candidates (index <= ptr); scanned downward so the lowest index wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) <= ptr)) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
        // Candidates after ptr take precedence, so this pass overrides the first.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) > ptr)) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(i);
            end
        end
    end

    // Decode the grant into the one-hot ready vector and steer the winner's operands.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (gnt_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[i*DATA_W +: DATA_W];
                mul_din1     = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Advance the RR pointer on a grant and shift the tag pipe whenever the multiplier advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= ID_W'(NUM_REQ - 1);
            tag_vld <= '0;
            // NOTE: the id stages are tiny and rsp_id must read 0 in reset, so they are cleared; wide datapath storage would normally be left unreset.
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else if (mul_ce) begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
            if (grant) begin
                ptr <= gnt_id;
            end
            tag_vld[0] <= grant;
            tag_id[0]  <= gnt_id;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

endmodule
